// File: rtl/pipe_ctrl.sv
// Decode, EX control register and hazard unit for a 5-stage pipeline: load-use stall,
// multi-cycle MUL hold and taken-branch flush, sequenced by a RUN/MUL_BUSY/FLUSH FSM.
module pipe_ctrl #(
    parameter int REG_AW       = 5,
    parameter int MUL_LAT      = 4,
    parameter int BR_FLUSH_CYC = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [6:0]        Op_i,
    input  logic              funct7_0_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              Zero_i,
    output logic [7:0]        ex_sig_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              flush_o,
    output logic              mul_busy_o,
    output logic [1:0]        dbg_state_o,
    output logic [3:0]        dbg_cnt_o
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam bit         MUL_MULTI  = (MUL_LAT > 1);
    localparam bit         FLUSH_MULTI = (BR_FLUSH_CYC > 1);
    localparam logic [3:0] MUL_CNT0   = 4'(MUL_LAT - 1);
    localparam logic [3:0] FLUSH_CNT0 = 4'(BR_FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        ex_sig_q, ex_sig_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

    logic [7:0] dec_sig;
    logic       in_run;
    logic       rs_match;
    logic       lu;
    logic       tb;
    logic       mul_acc;

    // Control word layout: RegWrite MemtoReg MemRead MemWrite ALUOp[1:0] ALUSrc Branch.
    always_comb begin
        dec_sig = 8'h00;
        if (valid_i) begin
            case (Op_i)
                OP_R:    dec_sig = 8'h88;
                OP_I:    dec_sig = 8'h8E;
                OP_LD:   dec_sig = 8'hE2;
                OP_ST:   dec_sig = 8'h12;
                OP_BR:   dec_sig = 8'h05;
                default: dec_sig = 8'h00;
            endcase
        end
    end

    always_comb begin
        in_run   = (state_q == ST_RUN);
        rs_match = (ex_rd_q != '0) && ((ex_rd_q == rs1_i) || (ex_rd_q == rs2_i));
        lu       = in_run && valid_i && ex_sig_q[5] && rs_match;
        tb       = in_run && !lu && valid_i && (Op_i == OP_BR) && Zero_i;
        mul_acc  = in_run && !lu && valid_i && (Op_i == OP_R) && funct7_0_i;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ex_sig_d = ex_sig_q;
        ex_rd_d  = ex_rd_q;
        case (state_q)
            ST_RUN: begin
                if (lu) begin
                    ex_sig_d = 8'h00;
                    ex_rd_d  = '0;
                end else begin
                    ex_sig_d = dec_sig;
                    ex_rd_d  = (dec_sig == 8'h00) ? '0 : rd_i;
                    if (tb && FLUSH_MULTI) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_CNT0;
                    end else if (mul_acc && MUL_MULTI) begin
                        state_d = ST_MUL_BUSY;
                        cnt_d   = MUL_CNT0;
                    end
                end
            end
            // EX keeps the MUL in place; the stalled ID instruction waits.
            ST_MUL_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_FLUSH: begin
                ex_sig_d = 8'h00;
                ex_rd_d  = '0;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_RUN;
            cnt_q    <= 4'd0;
            ex_sig_q <= 8'h00;
            ex_rd_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ex_sig_q <= ex_sig_d;
            ex_rd_q  <= ex_rd_d;
        end
    end

    // Hazard controls read idle while reset is held, even before the first edge clears state.
    always_comb begin
        stall_o      = rst_i && (lu || (state_q == ST_MUL_BUSY));
        flush_o      = rst_i && (tb || (state_q == ST_FLUSH));
        mul_busy_o   = rst_i && (state_q == ST_MUL_BUSY);
        pc_write_o   = !stall_o;
        ifid_write_o = !stall_o;
    end

    assign ex_sig_o    = ex_sig_q;
    assign ex_rd_o     = ex_rd_q;
    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios then random traffic,
// checked per cycle against a cycles-remaining reference model.
module tb_pipe_ctrl;

  localparam int AW = 5;
  localparam int MUL_LAT = 4;
  localparam int BR_FLUSH_CYC = 3;
  localparam int EW = 8 + AW + 5;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic valid_i = 1'b0;
  logic [6:0] op_i = '0;
  logic funct7_0_i = 1'b0;
  logic [AW-1:0] rs1_i = '0;
  logic [AW-1:0] rs2_i = '0;
  logic [AW-1:0] rd_i = '0;
  logic zero_i = 1'b0;
  logic [7:0] ex_sig_o;
  logic [AW-1:0] ex_rd_o;
  logic stall_o, pc_write_o, ifid_write_o, flush_o, mul_busy_o;
  logic [1:0] dbg_state_o;
  logic [3:0] dbg_cnt_o;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what EX currently holds and how many stall/flush cycles remain.
  logic [7:0] m_sig = 8'h00;
  logic [AW-1:0] m_rd = '0;
  int busy_left = 0;
  int flush_left = 0;

  pipe_ctrl #(.REG_AW(AW), .MUL_LAT(MUL_LAT), .BR_FLUSH_CYC(BR_FLUSH_CYC)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .Op_i(op_i), .funct7_0_i(funct7_0_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .Zero_i(zero_i),
    .ex_sig_o(ex_sig_o), .ex_rd_o(ex_rd_o), .stall_o(stall_o), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o), .flush_o(flush_o), .mul_busy_o(mul_busy_o),
    .dbg_state_o(dbg_state_o), .dbg_cnt_o(dbg_cnt_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] ref_decode(input logic v, input logic [6:0] op);
    if (!v) return 8'h00;
    case (op)
      OP_R: return 8'h88;
      OP_I: return 8'h8E;
      OP_LD: return 8'hE2;
      OP_ST: return 8'h12;
      OP_BR: return 8'h05;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void push(input logic [7:0] sig, input logic [AW-1:0] rd,
                               input logic st, input logic fl, input logic mb);
    exp_q.push_back({sig, rd, st, fl, !st, !st, mb});
  endfunction

  // Driver: apply one ID cycle, record the expected outputs, advance the model past the edge.
  task automatic cyc(input logic r, input logic v, input logic [6:0] op, input logic f7,
                     input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                     input logic [AW-1:0] d, input logic z);
    logic [7:0] dec;
    logic lu, taken;
    @(posedge clk);
    #1;
    rst_i = r; valid_i = v; op_i = op; funct7_0_i = f7;
    rs1_i = s1; rs2_i = s2; rd_i = d; zero_i = z;
    if (!r) begin
      push(m_sig, m_rd, 1'b0, 1'b0, 1'b0);
      m_sig = 8'h00; m_rd = '0; busy_left = 0; flush_left = 0;
    end else if (busy_left > 0) begin
      push(m_sig, m_rd, 1'b1, 1'b0, 1'b1);
      busy_left--;
    end else if (flush_left > 0) begin
      push(m_sig, m_rd, 1'b0, 1'b1, 1'b0);
      m_sig = 8'h00; m_rd = '0;
      flush_left--;
    end else begin
      dec = ref_decode(v, op);
      lu = v && m_sig[5] && (m_rd != 0) && ((m_rd == s1) || (m_rd == s2));
      if (lu) begin
        push(m_sig, m_rd, 1'b1, 1'b0, 1'b0);
        m_sig = 8'h00; m_rd = '0;
      end else begin
        taken = v && (op == OP_BR) && z;
        push(m_sig, m_rd, 1'b0, taken, 1'b0);
        if (taken) flush_left = BR_FLUSH_CYC - 1;
        if (v && (op == OP_R) && f7 && (MUL_LAT > 1)) busy_left = MUL_LAT - 1;
        m_sig = dec;
        m_rd = (dec == 8'h00) ? '0 : d;
      end
    end
  endtask

  task automatic nop();
    cyc(1'b1, 1'b0, 7'd0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented cycle is popped and compared away from the clock edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ex_sig", 32'(ex_sig_o), 32'(e[EW-1 -: 8]));
      check("ex_rd", 32'(ex_rd_o), 32'(e[AW+4:5]));
      check("stall", 32'(stall_o), 32'(e[4]));
      check("flush", 32'(flush_o), 32'(e[3]));
      check("pc_write", 32'(pc_write_o), 32'(e[2]));
      check("ifid_write", 32'(ifid_write_o), 32'(e[1]));
      check("mul_busy", 32'(mul_busy_o), 32'(e[0]));
    end
  end

  initial begin
    logic [6:0] ops[6];
    logic [6:0] op;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST; ops[4] = OP_BR;
    repeat (2) @(posedge clk);

    // Reset state observed with reset still asserted
    cyc(1'b0, 1'b1, OP_LD, 1'b0, 5'd1, 5'd1, 5'd9, 1'b1);
    nop();

    // Load x5 followed by add x6,x5,x1: one stall, bubble, then the add
    cyc(1'b1, 1'b1, OP_LD, 1'b0, 5'd2, 5'd0, 5'd5, 1'b0);
    cyc(1'b1, 1'b1, OP_R, 1'b0, 5'd5, 5'd1, 5'd6, 1'b0);
    cyc(1'b1, 1'b1, OP_R, 1'b0, 5'd5, 5'd1, 5'd6, 1'b0);
    nop(); nop();

    // Load x0 then a consumer of x0: no stall
    cyc(1'b1, 1'b1, OP_LD, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 1'b1, OP_R, 1'b0, 5'd0, 5'd0, 5'd3, 1'b0);
    nop();

    // MUL with three busy cycles, EX held at 8'h88
    cyc(1'b1, 1'b1, OP_R, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, OP_I, 1'b0, 5'd3, 5'd3, 5'd4, 1'b0);
    cyc(1'b1, 1'b1, OP_I, 1'b0, 5'd3, 5'd3, 5'd4, 1'b0);
    nop();

    // Taken beq: three flush cycles regardless of ID contents
    cyc(1'b1, 1'b1, OP_BR, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1);
    cyc(1'b1, 1'b1, OP_LD, 1'b0, 5'd1, 5'd2, 5'd7, 1'b0);
    cyc(1'b1, 1'b1, OP_BR, 1'b0, 5'd1, 5'd2, 5'd7, 1'b1);
    nop(); nop();

    // Load-use coinciding with a taken beq: stall first, then flush
    cyc(1'b1, 1'b1, OP_LD, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    cyc(1'b1, 1'b1, OP_BR, 1'b0, 5'd7, 5'd1, 5'd0, 1'b1);
    cyc(1'b1, 1'b1, OP_BR, 1'b0, 5'd7, 5'd1, 5'd0, 1'b1);
    nop(); nop(); nop();

    // Reset in the middle of MUL_BUSY, then a normal instruction
    cyc(1'b1, 1'b1, OP_R, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
    cyc(1'b1, 1'b1, OP_I, 1'b0, 5'd1, 5'd1, 5'd2, 1'b0);
    cyc(1'b0, 1'b1, OP_I, 1'b0, 5'd1, 5'd1, 5'd2, 1'b0);
    cyc(1'b1, 1'b1, OP_I, 1'b0, 5'd1, 5'd1, 5'd2, 1'b0);
    cyc(1'b1, 1'b1, OP_ST, 1'b0, 5'd2, 5'd1, 5'd4, 1'b0);
    nop();

    // Reset in the middle of FLUSH
    cyc(1'b1, 1'b1, OP_BR, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1);
    cyc(1'b0, 1'b1, OP_I, 1'b0, 5'd1, 5'd1, 5'd2, 1'b0);
    cyc(1'b1, 1'b1, OP_I, 1'b0, 5'd1, 5'd1, 5'd2, 1'b0);
    nop();

    // Random traffic on a small register set so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      ops[5] = 7'($urandom_range(0, 127));
      op = ops[$urandom_range(0, 5)];
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0), op,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
